// File: rtl/prog_mem_loader.sv
// prog_mem_loader: loadable instruction memory for the pipelined RISC core.
// A streaming valid/ready port fills the array from address 0. The fetch port
// returns words with one cycle of registered latency. Unloaded or out-of-range
// fetches return HALT_WORD.
// Optional build macro PROG_MEM_PARITY_EN adds a stored even-parity bit per
// word and a parity_err output.
module prog_mem_loader #(
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         DEPTH     = 4096,
    parameter int unsigned         ADDR_W    = 12,
    parameter logic [DATA_W-1:0]   HALT_WORD = DATA_W'(32'h0000_007F)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                load_done,
    output logic                load_ovf,
    output logic [ADDR_W:0]     load_count,
    input  logic                fetch_en,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_valid,
    output logic [DATA_W-1:0]   instruction,
    output logic                fetch_err
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic                parity_err
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic                wr_en;
    logic                clr_load;
    logic                fin_load;
    logic                set_ovf;
    logic                in_range;
    logic [MEM_W-1:0]    wr_word;
    logic [MEM_W-1:0]    rd_word;
    logic [MEM_W-1:0]    mem [DEPTH];

    // Handshake ready is a direct decode of the state register.
    assign ld_ready = (state == LOAD);

    // Unsigned compare at ADDR_W+1 bits so load_count == DEPTH never wraps.
    assign in_range = ({1'b0, fetch_addr} < load_count);

`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
`else
    assign wr_word = ld_data;
`endif

    assign rd_word = mem[fetch_addr[IDX_W-1:0]];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load-control decode; load_start always beats a data beat.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        clr_load  = 1'b0;
        fin_load  = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            IDLE, READY: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    clr_load  = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    clr_load = 1'b1;
                end else if (ld_valid) begin
                    wr_en = 1'b1;
                    if (ld_last) begin
                        state_nxt = READY;
                        fin_load  = 1'b1;
                    end else if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state_nxt = READY;
                        fin_load  = 1'b1;
                        set_ovf   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write pointer, word count and load status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            load_count <= '0;
            load_ovf   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= (state_nxt == READY);
            if (clr_load) begin
                ptr        <= '0;
                load_count <= '0;
                load_ovf   <= 1'b0;
            end else if (wr_en) begin
                ptr <= ptr + ADDR_W'(1);
                if (fin_load) begin
                    load_count <= {1'b0, ptr} + CNT_W'(1);
                end
                if (set_ovf) begin
                    load_ovf <= 1'b1;
                end
            end
        end
    end

    // Array write; contents survive reset and are fenced off by load_count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr[IDX_W-1:0]] <= wr_word;
        end
    end

    // Registered fetch port; result fields hold when no fetch is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            instruction <= HALT_WORD;
            fetch_err   <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            fetch_valid <= 1'b0;
            if (fetch_en && !load_start) begin
                if (state == READY) begin
                    fetch_valid <= 1'b1;
                    if (in_range) begin
                        fetch_err <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
                        if (^rd_word) begin
                            instruction <= HALT_WORD;
                            parity_err  <= 1'b1;
                        end else begin
                            instruction <= rd_word[DATA_W-1:0];
                            parity_err  <= 1'b0;
                        end
`else
                        instruction <= rd_word[DATA_W-1:0];
`endif
                    end else begin
                        instruction <= HALT_WORD;
                        fetch_err   <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
                        parity_err  <= 1'b0;
`endif
                    end
                end else if (state == IDLE) begin
                    fetch_valid <= 1'b1;
                    instruction <= HALT_WORD;
                    fetch_err   <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader (DEPTH=16, ADDR_W=5).
module tb_prog_mem_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 5;
    localparam logic [31:0] HALT   = 32'h0000_007F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              load_done;
    logic              load_ovf;
    logic [ADDR_W:0]   load_count;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [31:0]       instruction;
    logic              fetch_err;
`ifdef PROG_MEM_PARITY_EN
    logic              parity_err;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          addr_q[$];
    logic [31:0] m_mem [DEPTH];
    int          m_state;      // 0 idle, 1 load, 2 ready
    int          m_count;
    logic [31:0] last_instr;
    logic        last_err;
    int          checks   = 0;
    int          failures = 0;

    prog_mem_loader #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .load_done   (load_done),
        .load_ovf    (load_ovf),
        .load_count  (load_count),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .instruction (instruction),
        .fetch_err   (fetch_err)
`ifdef PROG_MEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_for(input int i);
        case (i)
            0:       return 32'h0060_0173;
            1:       return 32'h00A0_01F3;
            9:       return 32'h0000_007F;
            default: return $urandom;
        endcase
    endfunction

    function automatic exp_t expect_fetch(input int addr);
        exp_t e;
        if (m_state == 2 && addr < m_count) begin
            e.instr = m_mem[addr];
            e.err   = 1'b0;
        end else begin
            e.instr = HALT;
            e.err   = 1'b1;
        end
        return e;
    endfunction

    // Issue the queued addresses back-to-back and score each result.
    task automatic fetch_burst(input string tag);
        int n;
        n = addr_q.size();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_t e;
                checks++;
                if (fetch_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s valid[%0d]: got %b want 1", tag, i - 1, fetch_valid);
                end else if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s scoreboard empty at result %0d", tag, i - 1);
                end else begin
                    e = sb_q.pop_front();
                    if (instruction !== e.instr || fetch_err !== e.err) begin
                        failures++;
                        $display("FAIL %s fetch[%0d]: got instr=%h err=%b want instr=%h err=%b",
                                 tag, i - 1, instruction, fetch_err, e.instr, e.err);
                    end
                    last_instr = e.instr;
                    last_err   = e.err;
                end
            end
            if (i < n) begin
                fetch_en   = 1'b1;
                fetch_addr = ADDR_W'(addr_q[i]);
                sb_q.push_back(expect_fetch(addr_q[i]));
            end else begin
                fetch_en = 1'b0;
            end
        end
        addr_q.delete();
    endtask

    // Pulse load_start, stream n words (optional 3-cycle stall), check status.
    task automatic load_prog(input string tag, input int n, input bit with_last, input int stall_at);
        logic [31:0] w;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        m_state = 1;
        m_count = 0;
        checks++;
        if (ld_ready !== 1'b1 || load_done !== 1'b0 || load_ovf !== 1'b0 || load_count !== '0) begin
            failures++;
            $display("FAIL %s enter: got ready=%b done=%b ovf=%b count=%0d want 1 0 0 0",
                     tag, ld_ready, load_done, load_ovf, load_count);
        end
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    ld_valid = 1'b0;
                    ld_last  = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (ld_ready !== 1'b1 || load_done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s stall[%0d]: got ready=%b done=%b want 1 0",
                                 tag, s, ld_ready, load_done);
                    end
                end
            end
            w = word_for(i);
            m_mem[i] = w;
            ld_valid = 1'b1;
            ld_data  = w;
            ld_last  = with_last && (i == n - 1);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_state  = 2;
        m_count  = n;
        checks++;
        if (load_done !== 1'b1 || load_count !== (ADDR_W + 1)'(n) ||
            load_ovf !== (!with_last && n == DEPTH) || ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s end: got done=%b count=%0d ovf=%b ready=%b want 1 %0d %b 0",
                     tag, load_done, load_count, load_ovf, ld_ready, n, (!with_last && n == DEPTH));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
        fetch_en = 0; fetch_addr = '0;
        m_state = 0; m_count = 0; last_instr = HALT; last_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_ready !== 0 || load_done !== 0 || load_ovf !== 0 || load_count !== '0 ||
            fetch_valid !== 0 || instruction !== HALT || fetch_err !== 0) begin
            failures++;
            $display("FAIL reset: got rdy=%b done=%b ovf=%b cnt=%0d fv=%b ins=%h err=%b want 0 0 0 0 0 %h 0",
                     ld_ready, load_done, load_ovf, load_count, fetch_valid, instruction, fetch_err, HALT);
        end
    endtask

    task automatic test_fetch_before_load();
        addr_q = '{0, 7};
        fetch_burst("preload");
    endtask

    task automatic test_load_fetch();
        load_prog("load10", 10, 1'b1, 4);
        addr_q = '{0, 1};
        fetch_burst("b2b01");
        checks++;
        if (last_instr !== 32'h00A0_01F3) begin
            failures++;
            $display("FAIL word1: got %h want 00a001f3", last_instr);
        end
    endtask

    task automatic test_out_of_range();
        addr_q = '{10, 9, 31, 15, 2, 3, 4, 5, 6, 7, 8};
        fetch_burst("range");
    endtask

    task automatic test_overflow();
        load_prog("ovf16", 16, 1'b0, -1);
        addr_q = '{15, 16, 0};
        fetch_burst("ovf_fetch");
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        m_state = 1;
        m_count = 0;
        checks++;
        if (load_ovf !== 1'b0 || load_done !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: got ovf=%b done=%b ready=%b want 0 0 1", load_ovf, load_done, ld_ready);
        end
        fetch_en   = 1'b1;
        fetch_addr = '0;
        @(negedge clk);
        fetch_en = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || instruction !== last_instr || fetch_err !== last_err) begin
            failures++;
            $display("FAIL fetch_in_load: got fv=%b ins=%h err=%b want 0 %h %b",
                     fetch_valid, instruction, fetch_err, last_instr, last_err);
        end
        load_prog("reload10", 10, 1'b1, -1);
        addr_q = '{0, 9, 10};
        fetch_burst("reload_fetch");
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        rst_n    = 1'b0;
        m_state  = 0;
        m_count  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (load_done !== 1'b0 || load_count !== '0 || ld_ready !== 1'b0 || instruction !== HALT) begin
            failures++;
            $display("FAIL rst_mid: got done=%b count=%0d ready=%b ins=%h want 0 0 0 %h",
                     load_done, load_count, ld_ready, instruction, HALT);
        end
        addr_q = '{2, 0};
        fetch_burst("rst_fetch");
    endtask

    task automatic test_collisions();
        logic [31:0] w;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            @(negedge clk);
        end
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 32'hDEAD_BEEF;
        @(negedge clk);
        load_start = 1'b0;
        m_state = 1;
        m_count = 0;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA5A5_0000 | 32'(i);
            m_mem[i] = w;
            ld_valid = 1'b1;
            ld_data  = w;
            ld_last  = (i == 3);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_state  = 2;
        m_count  = 4;
        checks++;
        if (load_done !== 1'b1 || load_count !== (ADDR_W + 1)'(4)) begin
            failures++;
            $display("FAIL restart_count: got done=%b count=%0d want 1 4", load_done, load_count);
        end
        addr_q = '{0, 1, 2, 3, 4};
        fetch_burst("restart_fetch");
        @(negedge clk);
        load_start = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = '0;
        @(negedge clk);
        load_start = 1'b0;
        fetch_en   = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_vs_fetch: got fv=%b ready=%b want 0 1", fetch_valid, ld_ready);
        end
        load_prog("post3", 3, 1'b1, -1);
        addr_q = '{0, 1, 2, 3};
        fetch_burst("post_fetch");
    endtask

    initial begin
        test_reset();
        test_fetch_before_load();
        test_load_fetch();
        test_out_of_range();
        test_overflow();
        test_reset_mid_load();
        test_collisions();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Parametrised, loadable instruction memory for the pipelined RISC CPU, replacing the fixed program store. A streaming load port fills the array from address 0 under a valid/ready handshake. The fetch port then returns instructions with 1-cycle registered latency. Any read of an unloaded or out-of-range location returns a HALT word, so a short or missing program stops the core cleanly.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 4096, number of instruction words
ADDR_W, 12, word-address width; DEPTH <= 2**ADDR_W
HALT_WORD, 32'h0000007F, word returned for unloaded/invalid fetches (opcode 1111111)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse: begin new program load at address 0
ld_valid  in  1  load word valid
ld_data  in  DATA_W  load word
ld_last  in  1  marks final word of program, qualified by ld_valid
ld_ready  out  1  load port ready, high only in LOAD state
load_done  out  1  program present and fetchable (READY state)
load_ovf  out  1  sticky: DEPTH words accepted without ld_last
load_count  out  ADDR_W+1  number of words loaded
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  word address from PC
fetch_valid  out  1  instruction valid, 1 cycle after accepted fetch_en
instruction  out  DATA_W  fetched word
fetch_err  out  1  qualifies fetch_valid: address >= load_count or no program

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ld_ready=0, load_done=0, load_ovf=0, load_count=0.
  - fetch_valid=0, instruction=HALT_WORD, fetch_err=0, write pointer=0.
  - Array contents are not cleared; load_count=0 makes all of it unreachable.
- States:
  - IDLE: no program present.
  - LOAD: accepting load words.
  - READY: program present and fetchable.
- Transitions:
  - IDLE or READY + load_start -> LOAD. Pointer=0, load_count=0, load_ovf=0, load_done=0.
  - LOAD + load_start -> restart at LOAD, same clears.
  - LOAD + ld_valid&ld_ready -> mem[ptr]=ld_data, ptr+1.
  - LOAD, beat with ld_last=1 -> READY, load_count=ptr+1.
  - LOAD, beat at ptr==DEPTH-1 with ld_last=0 -> READY, load_count=DEPTH, load_ovf=1.
  - LOAD + load_start on the same cycle as a beat: load_start wins; the beat is dropped.
- Handshake:
  - ld_ready is combinationally equal to (state==LOAD).
  - A beat transfers only when ld_valid&ld_ready are both high.
  - ld_last with ld_valid=0 is ignored.
- Fetch:
  - fetch_en is registered.
  - In READY: next cycle fetch_valid=1.
    - If fetch_addr < load_count: instruction=mem[fetch_addr], fetch_err=0.
    - Otherwise: instruction=HALT_WORD, fetch_err=1.
  - In IDLE: fetch_valid=1, instruction=HALT_WORD, fetch_err=1.
  - In LOAD: fetch_en is ignored; fetch_valid=0 next cycle; instruction holds its last value.
  - fetch_en with load_start on the same cycle: the fetch is dropped, fetch_valid=0.
  - fetch_en=0: fetch_valid=0; instruction and fetch_err hold.
  - Back-to-back fetches give one result per cycle.
- Address compare is unsigned, ADDR_W+1 bits; no wrap-around.
- Reset mid-load: IDLE; every subsequent fetch returns HALT_WORD until a new load completes.

Optional Feature:
- Macro PROG_MEM_PARITY_EN.
- Defined:
  - Each word is stored with an extra even-parity bit, computed on write.
  - Extra output port parity_err (1 bit, reset 0) is checked on read and valid with fetch_valid.
  - On mismatch: parity_err=1 and instruction=HALT_WORD.
  - Unloaded/out-of-range fetches report parity_err=0.
- Undefined: no parity storage and no parity_err port.

Test Plan:
- Fetch before load: reset, fetch_en, addr 0 -> fetch_valid=1 next cycle, instruction=32'h0000007F, fetch_err=1.
- Load and fetch:
  - Load 10 words, ld_last on word 9.
  - Word 0 = 32'h00600173 (addi r2=r0+6); word 1 = 32'h00A001F3 (addi r3=r0+10); word 9 = 32'h0000007F.
  - Expect load_done=1, load_count=10.
  - Fetch addr 0 and addr 1 back-to-back -> 32'h00600173 then 32'h00A001F3, fetch_err=0.
- Out-of-range fetch: after a 10-word load, fetch addr 10 -> HALT_WORD with fetch_err=1; fetch addr 9 -> 32'h0000007F with fetch_err=0.
- Load stall and overflow:
  - Hold ld_valid=0 for 3 cycles mid-load -> ld_ready stays 1, pointer unchanged.
  - With DEPTH=16, send 16 words with no ld_last -> READY, load_count=16, load_ovf=1.
  - Next load_start -> load_ovf=0.
- Reset mid-load: drop rst_n after 5 beats -> load_done=0, load_count=0; fetch addr 2 -> HALT_WORD, fetch_err=1.
- Collisions:
  - load_start with ld_valid in LOAD -> beat dropped, load_count ends at the words sent after the restart.
  - load_start with fetch_en in READY -> fetch_valid=0 next cycle.
